output_collector: RTL and testbench

OUTPUT_COLLECTOR -- requirements
Module: output_collector

---
 rtl/output_collector.sv | 152 +++++++++++++++
 tb/tb_output_collector.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/output_collector.sv
// Deskews skewed systolic column sums into whole rows and hands them downstream via an N-entry FIFO.
// Optional macro OUTPUT_COLLECTOR_OVERFLOW_EN adds a sticky overflow flag for a start outside IDLE.
module output_collector #(
  parameter int unsigned MATRIX_SIZE = 2,
  parameter int unsigned DATA_SIZE   = 32,
  localparam int unsigned IW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] sum_in,
  output logic                                  collector_ready,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] row_out,
  output logic                                  row_valid,
  input  logic                                  row_ready,
  output logic [IW-1:0]                         row_index,
  output logic                                  matrix_done
`ifdef OUTPUT_COLLECTOR_OVERFLOW_EN
  ,
  output logic                                  overflow
`endif
);

  localparam int unsigned OW = $clog2(MATRIX_SIZE + 1);
  localparam logic [IW-1:0] LAST = IW'(MATRIX_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } state_e;

  typedef logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] row_t;

  state_e          state_q;
  logic [IW-1:0]   skew_q;
  logic [IW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [IW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic            row_valid_q;
  logic            collector_ready_q;
  logic            matrix_done_q;
  row_t            row_out_q, head_d;
  row_t            row_aln;
  row_t            mem_q [MATRIX_SIZE];
  logic            wr_en, pop, last_wr, last_pop;

  // Column j is delayed N-1-j cycles so every column of a row lines up together.
  for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_col
    localparam int unsigned DEPTH = MATRIX_SIZE - 1 - j;
    if (DEPTH == 0) begin : g_pass
      assign row_aln[j] = sum_in[j];
    end else begin : g_dly
      logic [DATA_SIZE-1:0] dly_q [DEPTH];
      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int k = 0; k < int'(DEPTH); k++) dly_q[k] <= '0;
        end else begin
          dly_q[0] <= sum_in[j];
          for (int k = 1; k < int'(DEPTH); k++) dly_q[k] <= dly_q[k-1];
        end
      end
      assign row_aln[j] = dly_q[DEPTH-1];
    end
  end

  // FIFO control; the head register is refreshed every cycle and bypasses a write into an empty head slot.
  always_comb begin
    wr_en    = (state_q == CAPTURE) && (skew_q == LAST);
    pop      = row_valid_q && row_ready;
    last_wr  = wr_en && (wr_ptr_q == LAST);
    last_pop = pop && (rd_ptr_q == LAST);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + IW'(1);
    if (pop)   rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + IW'(1);
    occ_d  = occ_q + OW'(wr_en) - OW'(pop);
    head_d = (wr_en && (wr_ptr_q == rd_ptr_d)) ? row_aln : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= row_aln;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q           <= IDLE;
      skew_q            <= '0;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      occ_q             <= '0;
      row_valid_q       <= 1'b0;
      row_out_q         <= '0;
      collector_ready_q <= 1'b1;
      matrix_done_q     <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      row_valid_q   <= (occ_d != '0);
      row_out_q     <= head_d;
      matrix_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q           <= CAPTURE;
            skew_q            <= IW'(1);
            collector_ready_q <= 1'b0;
          end
        end
        CAPTURE: begin
          if (skew_q != LAST) skew_q <= skew_q + IW'(1);
          if (last_wr) state_q <= DRAIN;
        end
        DRAIN: begin
          if (last_pop) begin
            state_q           <= IDLE;
            skew_q            <= '0;
            collector_ready_q <= 1'b1;
            matrix_done_q     <= 1'b1;
          end
        end
        default: begin
          state_q           <= IDLE;
          collector_ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef OUTPUT_COLLECTOR_OVERFLOW_EN
  logic overflow_q;

  // Sticky: a start while a matrix is still in flight means upstream ignored collector_ready.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (start && (state_q != IDLE)) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;
`endif

  assign collector_ready = collector_ready_q;
  assign row_out         = row_out_q;
  assign row_valid       = row_valid_q;
  assign row_index       = rd_ptr_q;
  assign matrix_done     = matrix_done_q;

endmodule

// File: tb/tb_output_collector.sv
// Directed bench for output_collector at N=2, DATA_SIZE=32 with a hand-derived cycle timeline.
module tb_output_collector;

  localparam int unsigned N  = 2;
  localparam int unsigned DW = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic                 row_ready;
  logic [N-1:0][DW-1:0] sum_in;
  logic [N-1:0][DW-1:0] row_out;
  logic                 collector_ready;
  logic                 row_valid;
  logic [0:0]           row_index;
  logic                 matrix_done;
`ifdef OUTPUT_COLLECTOR_OVERFLOW_EN
  logic                 overflow;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  output_collector #(.MATRIX_SIZE(N), .DATA_SIZE(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .sum_in         (sum_in),
    .collector_ready(collector_ready),
    .row_out        (row_out),
    .row_valid      (row_valid),
    .row_ready      (row_ready),
    .row_index      (row_index),
    .matrix_done    (matrix_done)
`ifdef OUTPUT_COLLECTOR_OVERFLOW_EN
    ,
    .overflow       (overflow)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One matrix: row0 = {r00,r01}, row1 = {r10,r11}; row_ready rises at cycle rdy_on.
  task automatic run_matrix(input string nm, input logic [31:0] r00, input logic [31:0] r01,
                            input logic [31:0] r10, input logic [31:0] r11,
                            input int rdy_on, input bit early);
    int   p0, p1;
    logic exp_valid, exp_rdy, exp_idx;
    p0 = (rdy_on > 2) ? rdy_on : 2;
    p1 = p0 + 1;
    for (int k = 0; k <= p1 + 1; k++) begin
      start     = (k == 0) || (early && (k == 1));
      row_ready = (k >= rdy_on);
      sum_in[0] = (k == 0) ? r00 : (k == 1) ? r10 : (32'hBAD0_0000 | 32'(k));
      sum_in[1] = (k == 1) ? r01 : (k == 2) ? r11 : (32'hBAD1_0000 | 32'(k));
      @(negedge clk);
      exp_valid = (k >= 2) && (k <= p1);
      exp_rdy   = (k == 0) || (k > p1);
      exp_idx   = (k > p0);
      check($sformatf("%s.valid@%0d", nm, k), 64'(row_valid), 64'(exp_valid));
      check($sformatf("%s.ready@%0d", nm, k), 64'(collector_ready), 64'(exp_rdy));
      check($sformatf("%s.done@%0d", nm, k), 64'(matrix_done), 64'(k == p1 + 1));
      if (exp_valid) begin
        check($sformatf("%s.index@%0d", nm, k), 64'(row_index), 64'(exp_idx));
        check($sformatf("%s.col0@%0d", nm, k), 64'(row_out[0]), 64'(exp_idx ? r10 : r00));
        check($sformatf("%s.col1@%0d", nm, k), 64'(row_out[1]), 64'(exp_idx ? r11 : r01));
      end
`ifdef OUTPUT_COLLECTOR_OVERFLOW_EN
      check($sformatf("%s.ovf@%0d", nm, k), 64'(overflow), 64'(early && (k >= 2)));
`endif
      @(posedge clk);
      #1;
    end
    start     = 1'b0;
    row_ready = 1'b0;
  endtask

  // Reset at cycle 2 with a coincident start: rows are dropped, no done pulse, start ignored.
  task automatic run_reset();
    logic exp_valid, exp_rdy;
    for (int k = 0; k <= 6; k++) begin
      start     = (k == 0) || (k == 2);
      reset     = (k != 2);
      row_ready = 1'b0;
      sum_in[0] = (k == 0) ? 32'd50 : (k == 1) ? 32'd60 : 32'd0;
      sum_in[1] = (k == 1) ? 32'd51 : (k == 2) ? 32'd61 : 32'd0;
      @(negedge clk);
      exp_valid = (k == 2);
      exp_rdy   = (k == 0) || (k >= 3);
      check($sformatf("rst.valid@%0d", k), 64'(row_valid), 64'(exp_valid));
      check($sformatf("rst.ready@%0d", k), 64'(collector_ready), 64'(exp_rdy));
      check($sformatf("rst.done@%0d", k), 64'(matrix_done), 64'(0));
      if (exp_valid) check($sformatf("rst.col0@%0d", k), 64'(row_out[0]), 64'(32'd50));
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b1;
    row_ready = 1'b0;
    sum_in    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.ready", 64'(collector_ready), 64'(1));
    check("reset.valid", 64'(row_valid), 64'(0));
    check("reset.index", 64'(row_index), 64'(0));
    check("reset.done", 64'(matrix_done), 64'(0));
`ifdef OUTPUT_COLLECTOR_OVERFLOW_EN
    check("reset.ovf", 64'(overflow), 64'(0));
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b0;

    run_matrix("basic", 32'd10, 32'd11, 32'd20, 32'd21, 0, 1'b0);
    run_matrix("bpress", 32'd10, 32'd11, 32'd20, 32'd21, 6, 1'b0);
    run_matrix("b2b_a", 32'd1, 32'd2, 32'd3, 32'd4, 0, 1'b0);
    run_matrix("b2b_b", 32'd30, 32'd31, 32'd40, 32'd41, 0, 1'b0);
    run_matrix("wide", 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 3, 1'b0);
    run_reset();
    run_matrix("after_rst", 32'd70, 32'd71, 32'd80, 32'd81, 0, 1'b0);
    run_matrix("early", 32'd10, 32'd11, 32'd20, 32'd21, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
